// File: rtl/fa.sv
// fa: single-bit full adder with a registered copy and optional registered primary outputs
module fa #(
  parameter int REG_OUT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout,
  output logic sum_q,
  output logic cout_q
);
  logic sum_c, cout_c;
  // Combinational sum and majority carry; X/Z on inputs propagates unmasked
  always_comb begin
    sum_c  = a ^ b ^ cin;
    cout_c = (a & b) | (a & cin) | (b & cin);
  end
  // Pipeline copy of the adder result, cleared asynchronously while rst_n is low
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sum_q  <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_c;
      cout_q <= cout_c;
    end
  // Primary outputs come from the register stage only when REG_OUT is set
  always_comb begin
    sum  = (REG_OUT != 0) ? sum_q  : sum_c;
    cout = (REG_OUT != 0) ? cout_q : cout_c;
  end
endmodule

// File: tb/tb_fa.sv
// tb_fa: checks combinational, registered and REG_OUT=1 behaviour of fa against an arithmetic model
module tb_fa;
  logic clk = 1'b0;
  logic run = 1'b0;
  logic rst_n, a, b, cin;
  logic s0, c0, sq0, cq0, s1, c1, sq1, cq1;
  int checks = 0;
  int errors = 0;
  logic [2:0] v;

  fa #(.REG_OUT(0)) u0 (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin),
                        .sum(s0), .cout(c0), .sum_q(sq0), .cout_q(cq0));
  fa #(.REG_OUT(1)) u1 (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin),
                        .sum(s1), .cout(c1), .sum_q(sq1), .cout_q(cq1));

  always begin
    #5;
    if (run) clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [1:0] ref_add(input logic x, input logic y, input logic z);
    return 2'(int'(x) + int'(y) + int'(z));
  endfunction

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; a = 1'b0; b = 1'b0; cin = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {a, b, cin} = v;
      #1;
      chk($sformatf("comb_%0d", i), {c0, s0}, ref_add(v[2], v[1], v[0]));
      chk($sformatf("regout_rst_%0d", i), {c1, s1}, 2'b00);
    end
    {a, b, cin} = 3'b111;
    #1;
    chk("rst_q", {cq0, sq0}, 2'b00);
    chk("rst_comb", {c0, s0}, 2'b11);
    chk("rst_regout", {c1, s1}, 2'b00);
    run = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    {a, b, cin} = 3'b101;
    @(posedge clk);
    #1;
    chk("latency_q", {cq0, sq0}, 2'b10);
    {a, b, cin} = 3'b000;
    #2;
    chk("hold_q", {cq0, sq0}, 2'b10);
    chk("hold_comb", {c0, s0}, 2'b00);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      v = 3'($urandom_range(0, 7));
      {a, b, cin} = v;
      #1;
      chk("rnd_comb", {c0, s0}, ref_add(v[2], v[1], v[0]));
      @(posedge clk);
      #1;
      chk("rnd_q", {cq0, sq0}, ref_add(v[2], v[1], v[0]));
      chk("rnd_regout", {c1, s1}, ref_add(v[2], v[1], v[0]));
      chk("rnd_regout_q", {cq1, sq1}, ref_add(v[2], v[1], v[0]));
    end
    @(negedge clk);
    {a, b, cin} = 3'b100;
    @(posedge clk);
    #1;
    chk("pre_async_q", {cq0, sq0}, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_q", {cq0, sq0}, 2'b00);
    chk("async_regout", {c1, s1}, 2'b00);
    chk("async_comb", {c0, s0}, 2'b01);
    @(negedge clk);
    rst_n = 1'b1;
    {a, b, cin} = 3'b111;
    #1;
    chk("regout_wait", {c1, s1}, 2'b00);
    chk("regout_wait_comb", {c0, s0}, 2'b11);
    @(posedge clk);
    #1;
    chk("regout_cap", {c1, s1}, 2'b11);
    chk("regout_cap_q", {cq0, sq0}, 2'b11);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
